// File: rtl/sigmoid_arbiter_pkg.sv
// Shared LSTM sigmoid packet types, plus the tag format and default latency
// used by the arbiter that shares one sigmoid between several gates.
package sigmoid_arbiter_pkg;

  localparam int DATA_W              = 16;
  localparam int DEFAULT_SIG_LATENCY = 2;
  localparam int MAX_REQ             = 8;
  // Tag id is sized for the largest supported requester count.
  localparam int SIG_ID_W            = $clog2(MAX_REQ);

  typedef struct packed {
    logic [DATA_W-1:0] data;
  } SIGMOID_INPUT_PACKET;

  typedef struct packed {
    logic [DATA_W-1:0] data;
  } SIGMOID_OUTPUT_PACKET;

  typedef struct packed {
    logic                valid;
    logic [SIG_ID_W-1:0] id;
  } SIG_TAG;

endpackage

// File: rtl/sigmoid_ret_fifo.sv
// Small synchronous return FIFO holding sigmoid results for one requester.
// Head word is presented combinationally; a write into a full FIFO is
// accepted only when the head is popped in the same cycle.
module sigmoid_ret_fifo
  import sigmoid_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              valid
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              pop;
  logic              push;
  logic              full;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign valid = (count_reg != '0);
  assign full  = (count_reg == CNT_W'(DEPTH));
  assign pop   = rd_en && valid;
  assign push  = wr_en && (!full || pop);

  assign rd_data = mem[rd_ptr_reg];

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/sigmoid_arbiter.sv
// Round-robin sharing of one pipelined sigmoid among NUM_REQ requesters,
// with tag-based result steering into credit-protected return FIFOs.
module sigmoid_arbiter
  import sigmoid_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int SIG_LATENCY = DEFAULT_SIG_LATENCY,
  parameter int RET_DEPTH   = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output SIGMOID_INPUT_PACKET        sig_packet_in,
  input  SIGMOID_OUTPUT_PACKET       sig_packet_out,
  output logic [NUM_REQ-1:0]         res_valid,
  output logic [NUM_REQ*DATA_W-1:0]  res_data,
  input  logic [NUM_REQ-1:0]         res_ready,
  output logic                       busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(RET_DEPTH + 1);

  logic [PW-1:0]     rr_ptr_reg;
  logic [DATA_W-1:0] in_data_reg;
  SIG_TAG            tag_pipe_reg [SIG_LATENCY+1];
  logic [CW-1:0]     credit_reg   [NUM_REQ];
  logic [CW-1:0]     credit_next  [NUM_REQ];
  logic              busy_reg;
  logic              busy_next;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] pop;
  logic [NUM_REQ-1:0] fifo_wr;
  logic               grant_any;
  logic [PW-1:0]      grant_idx;
  logic [DATA_W-1:0]  sel_data;

  // Nothing is granted while reset is held, regardless of stale credits.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = reset && req_valid[i] && (credit_reg[i] != '0);
    end
  end

  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    sel_data  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!grant_any && eligible[idx]) begin
        grant_any  = 1'b1;
        grant_idx  = PW'(idx);
        grant[idx] = 1'b1;
        sel_data   = req_data[idx*DATA_W +: DATA_W];
      end
    end
  end

  assign req_ready = grant;

  // RET_DEPTH - credit equals results in flight plus results waiting, so
  // the block is idle exactly when every credit is back home.
  always_comb begin
    busy_next = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      credit_next[i] = credit_reg[i];
      if (grant[i] && !pop[i]) begin
        credit_next[i] = credit_reg[i] - 1'b1;
      end else if (pop[i] && !grant[i]) begin
        credit_next[i] = credit_reg[i] + 1'b1;
      end
      if (credit_next[i] != CW'(RET_DEPTH)) begin
        busy_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rr_ptr_reg  <= '0;
      in_data_reg <= '0;
      busy_reg    <= 1'b0;
      for (int k = 0; k <= SIG_LATENCY; k++) begin
        tag_pipe_reg[k] <= '0;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        credit_reg[i] <= CW'(RET_DEPTH);
      end
    end else begin
      if (grant_any) begin
        rr_ptr_reg  <= (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        in_data_reg <= sel_data;
      end
      tag_pipe_reg[0] <= '{valid: grant_any, id: SIG_ID_W'(grant_idx)};
      for (int k = 1; k <= SIG_LATENCY; k++) begin
        tag_pipe_reg[k] <= tag_pipe_reg[k-1];
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        credit_reg[i] <= credit_next[i];
      end
      busy_reg <= busy_next;
    end
  end

  always_comb begin
    sig_packet_in      = '0;
    sig_packet_in.data = in_data_reg;
  end

  assign busy = busy_reg;

  // The last tag stage lines up with the sigmoid output of the same operand.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ret
      assign fifo_wr[gi] = tag_pipe_reg[SIG_LATENCY].valid &&
                           (tag_pipe_reg[SIG_LATENCY].id == SIG_ID_W'(gi));
      assign pop[gi]     = res_valid[gi] && res_ready[gi];

      sigmoid_ret_fifo #(
        .DEPTH (RET_DEPTH)
      ) u_ret_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (fifo_wr[gi]),
        .wr_data (sig_packet_out.data),
        .rd_en   (res_ready[gi]),
        .rd_data (res_data[gi*DATA_W +: DATA_W]),
        .valid   (res_valid[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_sigmoid_arbiter.sv
// Scoreboard bench: a high-level arbitration/credit model predicts grants and
// result arrival; a stand-in sigmoid pipeline models the shared unit.
module tb_sigmoid_arbiter;
  import sigmoid_arbiter_pkg::*;

  localparam int N = 3;
  localparam int L = 2;
  localparam int D = 2;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic [N-1:0]       req_valid = '0;
  logic [N*16-1:0]    req_data = '0;
  logic [N-1:0]       req_ready;
  SIGMOID_INPUT_PACKET  sig_in;
  SIGMOID_OUTPUT_PACKET sig_out;
  logic [N-1:0]       res_valid;
  logic [N*16-1:0]    res_data;
  logic [N-1:0]       res_ready = '0;
  logic               busy;

  sigmoid_arbiter #(
    .NUM_REQ     (N),
    .SIG_LATENCY (L),
    .RET_DEPTH   (D)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .sig_packet_in  (sig_in),
    .sig_packet_out (sig_out),
    .res_valid      (res_valid),
    .res_data       (res_data),
    .res_ready      (res_ready),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  // Injective stand-in for the sigmoid so any misrouted result is visible.
  function automatic logic [15:0] sig_fn(input logic [15:0] x);
    return {x[7:0], x[15:8]} ^ 16'h5A3C;
  endfunction

  logic [15:0] sig_pipe [L];
  always @(posedge clock) begin
    sig_pipe[0] <= sig_fn(sig_in.data);
    for (int k = 1; k < L; k++) sig_pipe[k] <= sig_pipe[k-1];
  end
  always_comb sig_out.data = sig_pipe[L-1];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int accept_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    int          due;
    logic [15:0] val;
  } exp_t;

  exp_t exp_q [N][$];
  int   credit_m [N];
  int   rr_m = 0;

  initial for (int i = 0; i < N; i++) credit_m[i] = D;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: compares what the DUT presents now, then advances the model
  // by the edge that is about to happen.
  always @(negedge clock) begin
    logic [N-1:0] exp_rv;
    logic [N-1:0] exp_ready;
    int g;
    int outstanding;
    exp_t e;

    exp_rv = '0;
    outstanding = 0;
    for (int i = 0; i < N; i++) begin
      exp_rv[i] = (exp_q[i].size() > 0) && (exp_q[i][0].due <= cyc);
      outstanding += D - credit_m[i];
    end
    chk("res_valid", 32'(res_valid), 32'(exp_rv));
    chk("busy", 32'(busy), 32'(outstanding != 0));

    g = -1;
    if (reset) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (rr_m + k) % N;
        if (g < 0 && req_valid[idx] && credit_m[idx] > 0) g = idx;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    if (reset && |(req_valid & req_ready)) accept_cnt++;

    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        exp_q[i].delete();
        credit_m[i] = D;
      end
      rr_m = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (exp_rv[i] && res_ready[i]) begin
          e = exp_q[i].pop_front();
          if (res_valid[i]) chk("res_data", 32'(res_data[i*16 +: 16]), 32'(e.val));
          credit_m[i]++;
        end
      end
      if (g >= 0) begin
        e.due = cyc + 2 + L;
        e.val = sig_fn(req_data[g*16 +: 16]);
        exp_q[g].push_back(e);
        credit_m[g]--;
        rr_m = (g + 1) % N;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) req_data[i*16 +: 16] = 16'($urandom);
  endtask

  initial begin
    int base;

    // Reset held for two edges with all requesters asking.
    req_valid = '1;
    step(2);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    reset = 1'b1;
    req_valid = '0;

    // Single operand from requester 1: 1.40625 in Q9.7.
    req_data[16 +: 16] = 16'b000000001_0110100;
    req_valid = 3'b010;
    step(1);
    req_valid = '0;
    step(3);
    chk("single_res_valid", 32'(res_valid), 32'b010);
    chk("single_res_data", 32'(res_data[16 +: 16]), 32'(sig_fn(16'h00B4)));
    res_ready = 3'b010;
    step(1);
    res_ready = '0;
    step(2);

    // All requesters streaming and popping every cycle.
    res_ready = '1;
    req_valid = '1;
    for (int c = 0; c < 12; c++) begin
      rand_data();
      step(1);
    end
    req_valid = '0;
    step(6);

    // Credit exhaustion on requester 0, then a single pop.
    base = accept_cnt;
    res_ready = '0;
    req_valid = 3'b001;
    rand_data();
    step(8);
    chk("stall_accepts", 32'(accept_cnt - base), 32'd2);
    chk("stall_ready_low", 32'(req_ready[0]), 32'd0);
    res_ready = 3'b001;
    step(1);
    res_ready = '0;
    step(8);
    chk("stall_one_more", 32'(accept_cnt - base), 32'd3);

    // Continuous pop with concurrent writes; order checked by scoreboard.
    res_ready = 3'b001;
    for (int c = 0; c < 10; c++) begin
      rand_data();
      step(1);
    end
    req_valid = '0;
    res_ready = '1;
    step(8);

    // Reset one cycle after two accepts; results must be dropped.
    res_ready = '0;
    req_valid = 3'b110;
    rand_data();
    step(2);
    req_valid = '0;
    step(1);
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    step(6);
    chk("flush_no_result", 32'(res_valid), 32'd0);
    chk("flush_busy", 32'(busy), 32'd0);
    req_valid = 3'b001;
    rand_data();
    step(1);
    req_valid = '0;
    step(4);
    chk("post_reset_result", 32'(res_valid), 32'b001);
    res_ready = '1;
    step(2);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      req_valid = N'($urandom);
      res_ready = N'($urandom);
      reset = ($urandom_range(0, 63) != 0);
      rand_data();
      step(1);
    end
    reset = 1'b1;
    req_valid = '0;
    res_ready = '1;
    step(12);
    chk("drain_busy", 32'(busy), 32'd0);
    chk("drain_res_valid", 32'(res_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
